// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared md_op encodings, FSM states and MD latency defaults
package pipe_hazard_ctrl_pkg;
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_MOVE = 2'b11;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  typedef enum logic [1:0] {RUN, MDWAIT, ENTRY} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_md.sv
// md_busy_counter: MD unit busy countdown (load on issue, decrement, saturate at 0)
//   clk, reset : clock, synchronous active-high reset
//   start, op  : E-stage MD issue and its md_op encoding
//   suppress   : blocks a coincident load (exception entry)
//   md_busy    : unit occupied, including the issue cycle itself
//   md_cnt     : remaining busy cycles
module md_busy_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       suppress,
  output logic       md_busy,
  output logic [3:0] md_cnt
);
  logic ld;
  assign ld = start & ~suppress;
  // the issue cycle counts as busy even though the count loads at the edge
  assign md_busy = (md_cnt != 4'd0) | (start & (op[1] ^ op[0]));
  always_ff @(posedge clk)
    if (reset) md_cnt <= '0;
    else if (ld && op == MD_MULT) md_cnt <= 4'(MULT_CYCLES);
    else if (ld && op == MD_DIV) md_cnt <= 4'(DIV_CYCLES);
    else if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the five-stage pipeline registers
//   clk, reset            : clock, synchronous active-high reset
//   stall_lu              : load-use hazard from decode
//   md_start, md_op       : E-stage MD issue and operation
//   d_uses_md             : D-stage instruction touches HI/LO or the MD unit
//   irq                   : CP0 interrupt/exception entry at M
//   eret_d                : eret in D
//   we_*, clr_*           : stage-register write enables and synchronous clears
//   md_busy, md_cnt       : MD occupancy and remaining cycles
//   in_entry              : first cycle after handler vector load
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_lu,
  input  logic       md_start,
  input  logic [1:0] md_op,
  input  logic       d_uses_md,
  input  logic       irq,
  input  logic       eret_d,
  output logic       we_fd,
  output logic       we_de,
  output logic       we_em,
  output logic       we_mw,
  output logic       clr_fd,
  output logic       clr_de,
  output logic       clr_em,
  output logic       clr_mw,
  output logic       md_busy,
  output logic [3:0] md_cnt,
  output logic       in_entry
);
  state_t state, nstate;
  logic md_stall, stall;
  md_busy_counter #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk(clk), .reset(reset), .start(md_start), .op(md_op), .suppress(irq),
    .md_busy(md_busy), .md_cnt(md_cnt)
  );
  assign md_stall = d_uses_md & md_busy;
  assign stall = stall_lu | md_stall;
  always_ff @(posedge clk)
    if (reset) state <= RUN;
    else state <= nstate;
  // irq flushes everything and loads the vector into E/M; stall freezes F/D, D/E
  // and bubbles E; eret only squashes the wrong-path fetch
  always_comb begin
    nstate = irq ? ENTRY : (state != ENTRY && stall && md_stall) ? MDWAIT : RUN;
    we_fd = irq | ~stall;
    we_de = irq | ~stall;
    we_em = 1'b1;
    we_mw = 1'b1;
    clr_fd = irq | (~stall & eret_d);
    clr_de = irq | stall;
    clr_em = irq;
    clr_mw = irq;
    in_entry = state == ENTRY;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic stall_lu = 0, md_start = 0, d_uses_md = 0, irq = 0, eret_d = 0;
  logic [1:0] md_op = 0;
  logic we_fd, we_de, we_em, we_mw, clr_fd, clr_de, clr_em, clr_mw, md_busy, in_entry;
  logic [3:0] md_cnt;
  int errors = 0, checks = 0;

  typedef struct packed {
    logic rst, lu, st; logic [1:0] op; logic du, irq, er;
    logic [3:0] we, clr; logic busy; logic [3:0] cnt; logic ent;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int rowq[$];

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .stall_lu(stall_lu), .md_start(md_start), .md_op(md_op),
    .d_uses_md(d_uses_md), .irq(irq), .eret_d(eret_d),
    .we_fd(we_fd), .we_de(we_de), .we_em(we_em), .we_mw(we_mw),
    .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
    .md_busy(md_busy), .md_cnt(md_cnt), .in_entry(in_entry)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] WN = 4'hF, WS = 4'h3, CN = 4'h0, CS = 4'h4, CI = 4'hF, CE = 4'h8;

  function automatic void add(input logic rst, lu, st, input logic [1:0] op, input logic du, iq, er,
                              input logic [3:0] we, clr, input logic busy, input logic [3:0] cnt, input logic ent);
    vec_t v;
    v = '{rst, lu, st, op, du, iq, er, we, clr, busy, cnt, ent};
    tbl.push_back(v);
  endfunction

  always @(negedge clk)
    if (sb.size() != 0) begin
      vec_t e;
      int r;
      logic [13:0] act, exp;
      e = sb.pop_front();
      r = rowq.pop_front();
      act = {we_fd, we_de, we_em, we_mw, clr_fd, clr_de, clr_em, clr_mw, md_busy, md_cnt, in_entry};
      exp = {e.we, e.clr, e.busy, e.cnt, e.ent};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL row%0d: we=%h clr=%h busy=%b cnt=%0d ent=%b, expected we=%h clr=%h busy=%b cnt=%0d ent=%b",
                 r, act[13:10], act[9:6], act[5], act[4:1], act[0], e.we, e.clr, e.busy, e.cnt, e.ent);
      end
    end

  initial begin
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    // mult issue then dependent mfhi in D from t+1
    add(0,0,1,2'b01,0,0,0, WN,CN,1,0,0);
    for (int i = 5; i >= 1; i--) add(0,0,0,2'b00,1,0,0, WS,CS,1,4'(i),0);
    add(0,0,0,2'b00,1,0,0, WN,CN,0,0,0);
    // div with no dependent instruction
    add(0,0,1,2'b10,0,0,0, WN,CN,1,0,0);
    for (int i = 10; i >= 1; i--) add(0,0,0,2'b00,0,0,0, WN,CN,1,4'(i),0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    // stall_lu with irq: irq wins, one ENTRY cycle
    add(0,1,0,2'b00,0,1,0, WN,CI,0,0,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,1);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    // irq suppresses coincident div load
    add(0,0,1,2'b10,0,1,0, WN,CI,1,0,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,1);
    // irq while count running at 4
    add(0,0,1,2'b01,0,0,0, WN,CN,1,0,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,1,5,0);
    add(0,0,0,2'b00,0,1,0, WN,CI,1,4,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,1,3,1);
    add(0,0,0,2'b00,0,0,0, WN,CN,1,2,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,1,1,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    // eret vs stall
    add(0,1,0,2'b00,0,0,1, WS,CS,0,0,0);
    add(0,0,0,2'b00,0,0,1, WN,CE,0,0,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    // irq reasserting holds ENTRY
    add(0,0,0,2'b00,0,1,0, WN,CI,0,0,0);
    add(0,0,0,2'b00,0,1,0, WN,CI,0,0,1);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,1);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    // reset mid-divide at count 7, with irq in the same cycle
    add(0,0,1,2'b10,0,0,0, WN,CN,1,0,0);
    for (int i = 10; i >= 8; i--) add(0,0,0,2'b00,0,0,0, WN,CN,1,4'(i),0);
    add(1,0,0,2'b00,0,1,0, WN,CI,1,7,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    // mthi/mtlo issue: no busy period; plain load-use stall
    add(0,0,1,2'b11,1,0,0, WN,CN,0,0,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);
    add(0,1,0,2'b00,0,0,0, WS,CS,0,0,0);
    add(0,0,0,2'b00,0,0,0, WN,CN,0,0,0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      reset = tbl[i].rst; stall_lu = tbl[i].lu; md_start = tbl[i].st; md_op = tbl[i].op;
      d_uses_md = tbl[i].du; irq = tbl[i].irq; eret_d = tbl[i].er;
      sb.push_back(tbl[i]);
      rowq.push_back(i);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
